// File: rtl/pulse_train_gen_pkg.sv
// pulse_train_gen_pkg: register map offsets, CTRL bit positions and channel state encoding
package pulse_train_gen_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_HIGH  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  localparam logic [7:0]  CMD_BASE_DEF = 8'h20;
  localparam logic [15:0] OFS_DELAY    = 16'd0;
  localparam logic [15:0] OFS_WIDTH    = 16'd4;
  localparam logic [15:0] OFS_GAP      = 16'd6;
  localparam logic [15:0] OFS_COUNT    = 16'd8;
  localparam logic [15:0] OFS_CTRL     = 16'd9;
  localparam logic [15:0] OFS_STATUS   = 16'd10;
  localparam int CTRL_ARM   = 0;
  localparam int CTRL_REARM = 1;
  localparam int CTRL_OVR   = 2;
endpackage

// File: rtl/pulse_train_gen_if.sv
// pulse_train_gen_if: cmd_handler register bus (command, byte index, data, strobes)
interface pulse_train_gen_if;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        reg_read;
  logic        reg_write;
  modport master (output reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write, input reg_data_out);
  modport slave  (input reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write, output reg_data_out);
endinterface

// File: rtl/pulse_train_gen_channel.sv
// pulse_train_gen_channel: one channel's config registers, delay/pulse FSM, counters and read mux
module pulse_train_gen_channel
  import pulse_train_gen_pkg::*;
#(
  parameter int DLY_W = 32,
  parameter int PW_W  = 16
) (
  input  logic        clkin,
  input  logic        reset_n,
  input  logic        rise,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [15:0] idx,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        pulse,
  output logic        busy
);
  localparam int CW = DLY_W > PW_W ? DLY_W : PW_W;
  logic [DLY_W-1:0] dly;
  logic [PW_W-1:0]  wid, gap, wid_w, gap_w;
  logic [7:0]       count, left, left_n, rd_mux;
  logic [CW-1:0]    cnt, cnt_n;
  logic             arm, rearm, ovr, wr_ctrl, accept, abort, last;
  state_t           state, state_n;
  assign busy    = state inside {S_DELAY, S_HIGH, S_GAP};
  assign wr_ctrl = wr_en && idx == OFS_CTRL;
  assign accept  = state == S_IDLE && arm && rise;
  assign abort   = busy && wr_ctrl && !wdata[CTRL_ARM];
  assign last    = cnt <= CW'(1);
  always_ff @(posedge clkin or negedge reset_n)
    if (!reset_n) begin
      dly   <= '0;
      wid   <= '0;
      gap   <= '0;
      count <= '0;
      arm   <= 1'b0;
      rearm <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (state == S_DONE && !rearm) arm <= 1'b0;
      ovr <= (rise & busy) | (ovr & ~(wr_ctrl & wdata[CTRL_OVR]));
      if (wr_en) begin
        for (int b = 0; b < DLY_W/8; b++)
          if (idx == 16'(OFS_DELAY + 16'(b))) dly[8*b +: 8] <= wdata;
        for (int b = 0; b < PW_W/8; b++) begin
          if (idx == 16'(OFS_WIDTH + 16'(b))) wid[8*b +: 8] <= wdata;
          if (idx == 16'(OFS_GAP + 16'(b))) gap[8*b +: 8] <= wdata;
        end
        if (idx == OFS_COUNT) count <= wdata;
        if (wr_ctrl) begin
          arm   <= wdata[CTRL_ARM];
          rearm <= wdata[CTRL_REARM];
        end
      end
    end
  // width/gap are snapshotted on accept so config writes only affect the next train
  always_ff @(posedge clkin or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      left  <= '0;
      wid_w <= '0;
      gap_w <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      left  <= left_n;
      pulse <= state_n == S_HIGH;
      if (accept) begin
        wid_w <= wid;
        gap_w <= gap;
      end
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    left_n  = left;
    case (state)
      S_IDLE:
        if (accept) begin
          left_n  = count;
          cnt_n   = dly != '0 ? CW'(dly) : CW'(wid);
          state_n = dly != '0 ? S_DELAY : (count != '0 ? S_HIGH : S_DONE);
        end
      S_DELAY, S_GAP:
        if (last) begin
          cnt_n   = CW'(wid_w);
          state_n = left != '0 ? S_HIGH : S_DONE;
        end else cnt_n = cnt - CW'(1);
      S_HIGH:
        if (last) begin
          cnt_n   = CW'(gap_w);
          left_n  = left - 8'd1;
          state_n = S_GAP;
        end else cnt_n = cnt - CW'(1);
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end
  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < DLY_W/8; b++)
      if (idx == 16'(OFS_DELAY + 16'(b))) rd_mux = dly[8*b +: 8];
    for (int b = 0; b < PW_W/8; b++) begin
      if (idx == 16'(OFS_WIDTH + 16'(b))) rd_mux = wid[8*b +: 8];
      if (idx == 16'(OFS_GAP + 16'(b))) rd_mux = gap[8*b +: 8];
    end
    if (idx == OFS_COUNT) rd_mux = count;
    if (idx == OFS_CTRL) rd_mux = {5'b0, ovr, rearm, arm};
    if (idx == OFS_STATUS) rd_mux = {5'b0, state};
  end
  always_ff @(posedge clkin or negedge reset_n)
    if (!reset_n) rdata <= '0;
    else rdata <= rd_en ? rd_mux : '0;
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: shared trigger edge detect, per-channel address decode and OR-combined read data
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int         CHANNELS = 2,
  parameter int         DLY_W    = 32,
  parameter int         PW_W     = 16,
  parameter logic [7:0] CMD_BASE = CMD_BASE_DEF
) (
  input  logic                clkin,
  input  logic                reset_n,
  input  logic                trigger_in,
  pulse_train_gen_if.slave    bus,
  output logic [CHANNELS-1:0] trigger_out,
  output logic [CHANNELS-1:0] busy
);
  logic       trig_q, rise;
  logic [7:0] rd;
  logic [7:0] ch_rd [CHANNELS];
  always_ff @(posedge clkin or negedge reset_n)
    if (!reset_n) trig_q <= 1'b0;
    else trig_q <= trigger_in;
  assign rise = trigger_in & ~trig_q;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic sel;
    assign sel = bus.reg_cmd == 8'(CMD_BASE + 8'(k));
    pulse_train_gen_channel #(.DLY_W(DLY_W), .PW_W(PW_W)) u_ch (
      .clkin   (clkin),
      .reset_n (reset_n),
      .rise    (rise),
      .wr_en   (sel && bus.reg_write),
      .rd_en   (sel && bus.reg_read),
      .idx     (bus.reg_bytecount),
      .wdata   (bus.reg_data_in),
      .rdata   (ch_rd[k]),
      .pulse   (trigger_out[k]),
      .busy    (busy[k])
    );
  end
  always_comb begin
    rd = '0;
    for (int i = 0; i < CHANNELS; i++) rd = rd | ch_rd[i];
  end
  assign bus.reg_data_out = rd;
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed scenarios plus random traffic against a timeline-based reference model
module tb_pulse_train_gen;
  localparam int CH = 2;
  logic          clkin = 1'b0;
  logic          reset_n = 1'b0;
  logic          trigger_in = 1'b0;
  logic [CH-1:0] trigger_out, busy;
  pulse_train_gen_if bus();
  pulse_train_gen #(.CHANNELS(CH)) dut (
    .clkin       (clkin),
    .reset_n     (reset_n),
    .trigger_in  (trigger_in),
    .bus         (bus),
    .trigger_out (trigger_out),
    .busy        (busy)
  );
  always #5 clkin = ~clkin;
  int          vectors = 0, errors = 0, cyc = 0, hi;
  logic [31:0] m_dly [CH];
  logic [15:0] m_wid [CH], m_gap [CH];
  logic [7:0]  m_cnt [CH];
  bit          m_arm [CH], m_rearm [CH], m_ovr [CH], m_run [CH];
  longint      t0 [CH], ld [CH], lw [CH], lg [CH], lc [CH];
  bit          trig_prev;
  logic [7:0]  exp_rd;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_dly[c] = 0; m_wid[c] = 0; m_gap[c] = 0; m_cnt[c] = 0;
      m_arm[c] = 0; m_rearm[c] = 0; m_ovr[c] = 0; m_run[c] = 0;
    end
    trig_prev = 0;
    exp_rd = 0;
  endtask
  // 0 idle, 1 delay, 2 high, 3 gap, 4 done: derived from cycles elapsed since the accepted rise
  function automatic int phase(int c);
    longint k, p, l;
    if (!m_run[c]) return 0;
    k = longint'(cyc) - t0[c];
    p = lw[c] + lg[c];
    l = ld[c] + lc[c] * p;
    if (k < 1 || k > l + 1) return 0;
    if (k == l + 1) return 4;
    if (k <= ld[c]) return 1;
    return ((k - ld[c] - 1) % p < lw[c]) ? 2 : 3;
  endfunction
  function automatic logic [7:0] reg_byte(int c, int idx);
    case (idx)
      0, 1, 2, 3: return 8'(m_dly[c] >> (8*idx));
      4, 5:       return 8'(m_wid[c] >> (8*(idx-4)));
      6, 7:       return 8'(m_gap[c] >> (8*(idx-6)));
      8:          return m_cnt[c];
      9:          return {5'b0, m_ovr[c], m_rearm[c], m_arm[c]};
      10:         return 8'(phase(c));
      default:    return 8'h00;
    endcase
  endfunction
  task automatic step();
    logic [CH-1:0] eo, eb;
    logic [7:0]    nrd, d;
    bit            rise, bsy, sel, wctl;
    int            ph, idx;
    @(negedge clkin);
    for (int c = 0; c < CH; c++) begin
      ph = phase(c);
      eo[c] = ph == 2;
      eb[c] = ph >= 1 && ph <= 3;
    end
    check("trigger_out", trigger_out, eo);
    check("busy", busy, eb);
    check("reg_data_out", bus.reg_data_out, exp_rd);
    nrd = 0;
    if (bus.reg_read)
      for (int c = 0; c < CH; c++)
        if (bus.reg_cmd == 8'(32'h20 + c)) nrd = reg_byte(c, int'(bus.reg_bytecount));
    rise = trigger_in && !trig_prev;
    trig_prev = trigger_in;
    for (int c = 0; c < CH; c++) begin
      ph = phase(c);
      bsy = ph >= 1 && ph <= 3;
      sel = bus.reg_write && bus.reg_cmd == 8'(32'h20 + c);
      idx = int'(bus.reg_bytecount);
      d = bus.reg_data_in;
      wctl = sel && idx == 9;
      if (ph == 0 && m_arm[c] && rise) begin
        m_run[c] = 1; t0[c] = cyc; ld[c] = longint'(m_dly[c]); lc[c] = longint'(m_cnt[c]);
        lw[c] = m_wid[c] == 0 ? 1 : longint'(m_wid[c]);
        lg[c] = m_gap[c] == 0 ? 1 : longint'(m_gap[c]);
      end else if (bsy && wctl && !d[0]) m_run[c] = 0;
      if (ph == 4 && !m_rearm[c]) m_arm[c] = 0;
      m_ovr[c] = (rise && bsy) || (m_ovr[c] && !(wctl && d[2]));
      if (sel)
        case (idx)
          0, 1, 2, 3: m_dly[c] = (m_dly[c] & ~(32'hFF << (8*idx))) | (32'(d) << (8*idx));
          4, 5:       m_wid[c] = (m_wid[c] & ~(16'hFF << (8*(idx-4)))) | (16'(d) << (8*(idx-4)));
          6, 7:       m_gap[c] = (m_gap[c] & ~(16'hFF << (8*(idx-6)))) | (16'(d) << (8*(idx-6)));
          8:          m_cnt[c] = d;
          9:          begin m_arm[c] = d[0]; m_rearm[c] = d[1]; end
          default:    ;
        endcase
    end
    exp_rd = nrd;
    @(posedge clkin);
    #1;
    cyc++;
  endtask
  task automatic wr(int c, int idx, int val);
    bus.reg_cmd = 8'(32'h20 + c); bus.reg_bytecount = 16'(idx); bus.reg_data_in = 8'(val);
    bus.reg_write = 1;
    step();
    bus.reg_write = 0;
  endtask
  task automatic rd_expect(string tag, int c, int idx, logic [7:0] exp);
    bus.reg_cmd = 8'(32'h20 + c); bus.reg_bytecount = 16'(idx);
    bus.reg_read = 1;
    step();
    bus.reg_read = 0;
    check(tag, bus.reg_data_out, exp);
  endtask
  task automatic count_high(int c, int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      step();
      h += int'(trigger_out[c]);
    end
  endtask
  initial begin
    bus.reg_cmd = 0; bus.reg_bytecount = 0; bus.reg_data_in = 0; bus.reg_read = 0; bus.reg_write = 0;
    repeat (3) @(posedge clkin);
    #1;
    check("rst_trigger_out", trigger_out, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", bus.reg_data_out, 0);
    @(negedge clkin) reset_n = 1;
    model_reset();
    @(posedge clkin);
    #1;
    cyc++;
    // three pulses of 3 high / 2 low after a 5-cycle delay
    wr(0, 0, 5); wr(0, 4, 3); wr(0, 6, 2); wr(0, 8, 3); wr(0, 9, 1);
    trigger_in = 1;
    for (int i = 1; i <= 22; i++) begin
      step();
      trigger_in = 0;
      check("t1_pulse", trigger_out[0], i inside {[6:8], [11:13], [16:18]});
    end
    // zero delay and width give one single-cycle pulse, then ARM self-clears
    wr(0, 0, 0); wr(0, 4, 0); wr(0, 8, 1); wr(0, 9, 1);
    trigger_in = 1;
    step();
    trigger_in = 0;
    check("t2_pulse_t1", trigger_out[0], 1);
    step();
    check("t2_pulse_t2", trigger_out[0], 0);
    repeat (6) step();
    rd_expect("t2_ctrl", 0, 9, 8'h00);
    // rise during HIGH is an overrun; W1C clears it
    wr(0, 0, 1); wr(0, 4, 4); wr(0, 6, 1); wr(0, 8, 2); wr(0, 9, 3);
    trigger_in = 1;
    step();
    trigger_in = 0;
    step();
    step();
    trigger_in = 1;
    step();
    trigger_in = 0;
    repeat (14) step();
    rd_expect("t3_ctrl_ovr", 0, 9, 8'h07);
    wr(0, 9, 7);
    rd_expect("t3_ctrl_w1c", 0, 9, 8'h03);
    // two channels, different delays, same rise
    wr(0, 0, 10); wr(0, 4, 2); wr(0, 8, 1);
    wr(1, 0, 2); wr(1, 4, 2); wr(1, 6, 1); wr(1, 8, 1); wr(1, 9, 1);
    trigger_in = 1;
    for (int i = 1; i <= 15; i++) begin
      step();
      trigger_in = 0;
      check("t4_ch1_out", trigger_out[1], i inside {[3:4]});
      check("t4_ch0_out", trigger_out[0], i inside {[11:12]});
      check("t4_ch1_busy", busy[1], i inside {[1:5]});
      check("t4_ch0_busy", busy[0], i inside {[1:13]});
    end
    // width rewritten mid-train only takes effect on the next trigger
    wr(1, 8, 2); wr(1, 9, 1);
    trigger_in = 1;
    step();
    trigger_in = 0;
    wr(1, 4, 8);
    count_high(1, 12, hi);
    check("t5_old_width", hi, 4);
    wr(1, 9, 1);
    trigger_in = 1;
    step();
    trigger_in = 0;
    count_high(1, 30, hi);
    check("t5_new_width", hi, 16);
    // ARM cleared mid-GAP aborts the train
    wr(0, 0, 1); wr(0, 4, 3); wr(0, 6, 5); wr(0, 8, 3); wr(0, 9, 3);
    trigger_in = 1;
    step();
    trigger_in = 0;
    repeat (5) step();
    wr(0, 9, 0);
    check("t6_abort_out", trigger_out[0], 0);
    check("t6_abort_busy", busy[0], 0);
    rd_expect("t6_status_idle", 0, 10, 8'h00);
    rd_expect("t6_unmapped_cmd", CH, 9, 8'h00);
    // asynchronous reset in the middle of a HIGH phase
    wr(0, 9, 1);
    trigger_in = 1;
    step();
    trigger_in = 0;
    step();
    check("t6_high_before_rst", trigger_out[0], 1);
    #2 reset_n = 0;
    #1 check("t6_async_rst", trigger_out, 0);
    repeat (2) @(posedge clkin);
    @(negedge clkin) reset_n = 1;
    model_reset();
    @(posedge clkin);
    #1;
    cyc++;
    rd_expect("t6_rst_width", 0, 4, 8'h00);
    rd_expect("t6_rst_status", 0, 10, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      int         c, idx;
      logic [7:0] d;
      c = $urandom_range(0, CH);
      idx = $urandom_range(0, 12);
      case (idx)
        0:             d = 8'($urandom_range(0, 12));
        4, 6, 8:       d = 8'($urandom_range(0, 4));
        9:             d = 8'($urandom_range(0, 7)) | 8'($urandom_range(0, 3) != 0);
        1, 2, 3, 5, 7: d = 8'h00;
        default:       d = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) trigger_in = ~trigger_in;
      bus.reg_cmd = 8'(32'h20 + c);
      bus.reg_bytecount = 16'(idx);
      bus.reg_data_in = d;
      bus.reg_write = $urandom_range(0, 5) == 0;
      bus.reg_read = $urandom_range(0, 2) == 0;
      step();
    end
    bus.reg_write = 0;
    bus.reg_read = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
